// File: rtl/rom_script_fetcher.sv
// rom_script_fetcher: walks the script ROM from a start address, prefetching words into a FIFO until END.
// Optional per-script fetch watchdog: define ROM_FETCH_WATCHDOG_EN.
module rom_script_fetcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WORDS  = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [9:0]  start_addr,
   input  logic        abort,
   output logic [9:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_data,
   output logic        cmd_last,
   output logic        busy,
   output logic        err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state, state_nx;
   logic [7:0] ptr;
   logic in_flight;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] count;
   logic go, issue, push, pop, flush, hit_end, room, wd_ok, trip;
   logic unused_ok;
   assign unused_ok = ^{start_addr[1:0], 1'(MAX_WORDS)};
   assign rom_addr = {ptr, 2'b00};
   assign cmd_valid = count != '0;
   assign cmd_data = mem[rp];
   assign cmd_last = cmd_valid && cmd_data[31:28] == 4'hF;
   // The in-flight word already owns a FIFO slot, so a full FIFO can never overflow
   assign room = (count + (AW+1)'(in_flight)) < (AW+1)'(FIFO_DEPTH);
   always_comb begin
      start_ready = state == IDLE;
      busy = state != IDLE;
      go = start_ready && start_valid && !abort;
      flush = (busy && abort) || trip;
      push = state == FETCH && in_flight && !abort;
      hit_end = push && rom_data[31:28] == 4'hF;
      pop = cmd_valid && cmd_ready;
      issue = state == FETCH && !abort && !hit_end && room && wd_ok;
      state_nx = flush ? IDLE :
                 go ? FETCH :
                 hit_end ? DRAIN :
                 (state == DRAIN && pop && cmd_last) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         in_flight <= 1'b0;
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         in_flight <= issue;
         ptr <= go ? start_addr[9:2] : issue ? ptr + 8'd1 : ptr;
         if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
         end else begin
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= rom_data;
`ifdef ROM_FETCH_WATCHDOG_EN
   localparam int WW = $clog2(MAX_WORDS + 1);
   logic [WW-1:0] words;
   assign wd_ok = words < WW'(MAX_WORDS);
   // Trip only once the last read has landed, so an END in that word still wins
   assign trip = state == FETCH && !wd_ok && !in_flight && !abort;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         words <= '0;
         err <= 1'b0;
      end else if (go) begin
         words <= '0;
         err <= 1'b0;
      end else begin
         words <= words + WW'(issue);
         if (trip) err <= 1'b1;
      end
`else
   assign wd_ok = 1'b1;
   assign trip = 1'b0;
   assign err = 1'b0;
`endif
endmodule
